light_seq_monitor: RTL and testbench

LIGHT_SEQ_MONITOR -- requirements
Module: light_seq_monitor

---
 rtl/light_pkg.sv | 75 +++++++
 rtl/lsm_dwell_ctr.sv | 46 ++++
 rtl/light_seq_monitor.sv | 130 +++++++++++++
 tb/tb_light_seq_monitor.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
// light_pkg : light codes, phase-pattern table and dwell table for light_seq_monitor
// Rev 1.0
// ============================================================================
package light_pkg;

  localparam logic [1:0] c_green  = 2'b00;
  localparam logic [1:0] c_yellow = 2'b01;
  localparam logic [1:0] c_red    = 2'b10;
  localparam logic [1:0] c_redyel = 2'b11;

  localparam int unsigned c_num_phases = 18;

  typedef enum logic [0:0] {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } lsm_state_t;

  // Packed as {hw1, hw2, fw1, fw2}, hw1 in the top bits.
  function automatic logic [7:0] phase_pattern(input logic [4:0] p);
    case (p)
      5'd0:    phase_pattern = {c_red,    c_red,    c_red,    c_red};
      5'd1:    phase_pattern = {c_redyel, c_redyel, c_red,    c_red};
      5'd2:    phase_pattern = {c_green,  c_green,  c_red,    c_red};
      5'd3:    phase_pattern = {c_green,  c_yellow, c_red,    c_red};
      5'd4:    phase_pattern = {c_green,  c_red,    c_red,    c_red};
      5'd5:    phase_pattern = {c_yellow, c_red,    c_red,    c_red};
      5'd6:    phase_pattern = {c_red,    c_red,    c_red,    c_red};
      5'd7:    phase_pattern = {c_red,    c_red,    c_redyel, c_redyel};
      5'd8:    phase_pattern = {c_red,    c_red,    c_green,  c_green};
      5'd9:    phase_pattern = {c_red,    c_red,    c_green,  c_yellow};
      5'd10:   phase_pattern = {c_red,    c_red,    c_green,  c_red};
      5'd11:   phase_pattern = {c_red,    c_red,    c_yellow, c_redyel};
      5'd12:   phase_pattern = {c_red,    c_red,    c_red,    c_green};
      5'd13:   phase_pattern = {c_red,    c_red,    c_red,    c_yellow};
      5'd14:   phase_pattern = {c_red,    c_red,    c_red,    c_red};
      5'd15:   phase_pattern = {c_red,    c_redyel, c_red,    c_red};
      5'd16:   phase_pattern = {c_red,    c_green,  c_red,    c_red};
      5'd17:   phase_pattern = {c_red,    c_yellow, c_red,    c_red};
      default: phase_pattern = {c_red,    c_red,    c_red,    c_red};
    endcase
  endfunction

  // Nominal controller dwell per phase; the minimum legal dwell is one more.
  function automatic logic [7:0] d_table(input logic [4:0] p);
    case (p)
      5'd0:    d_table = 8'd1;
      5'd1:    d_table = 8'd2;
      5'd2:    d_table = 8'd30;
      5'd3:    d_table = 8'd2;
      5'd4:    d_table = 8'd10;
      5'd5:    d_table = 8'd2;
      5'd6:    d_table = 8'd1;
      5'd7:    d_table = 8'd2;
      5'd8:    d_table = 8'd15;
      5'd9:    d_table = 8'd2;
      5'd10:   d_table = 8'd5;
      5'd11:   d_table = 8'd2;
      5'd12:   d_table = 8'd10;
      5'd13:   d_table = 8'd2;
      5'd14:   d_table = 8'd1;
      5'd15:   d_table = 8'd2;
      5'd16:   d_table = 8'd15;
      5'd17:   d_table = 8'd3;
      default: d_table = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] min_dwell(input logic [4:0] p);
    min_dwell = d_table(p) + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsm_dwell_ctr.sv
`default_nettype none
// ============================================================================
// lsm_dwell_ctr : saturating per-phase dwell counter with optional minimum-dwell
//                 compare (enabled by LSM_DWELL_CHECK_EN)
// Rev 1.0
// ============================================================================
module lsm_dwell_ctr
  import light_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_inc,
`ifdef LSM_DWELL_CHECK_EN
  input  logic       i_check,
  input  logic [4:0] i_phase,
`endif
  output logic [7:0] o_dwell,
  output logic       o_short
);

  logic [7:0] r_dwell;

  // Neither load nor increment means the monitor is unsynchronised: clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell <= 8'd0;
    end else if (i_load) begin
      r_dwell <= 8'd1;
    end else if (i_inc) begin
      if (r_dwell != 8'hFF) r_dwell <= r_dwell + 8'd1;
    end else begin
      r_dwell <= 8'd0;
    end
  end

  assign o_dwell = r_dwell;

`ifdef LSM_DWELL_CHECK_EN
  assign o_short = i_check && (r_dwell < min_dwell(i_phase));
`else
  assign o_short = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/light_seq_monitor.sv
`default_nettype none
// ============================================================================
// light_seq_monitor : tracks the 18-phase traffic-light sequence, flags sequence,
//                     conflict and (LSM_DWELL_CHECK_EN) short-dwell errors
// Rev 1.0
// ============================================================================
module light_seq_monitor
  import light_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           hw1,
  input  logic [1:0]           hw2,
  input  logic [1:0]           fw1,
  input  logic [1:0]           fw2,
  output logic                 locked,
  output logic [4:0]           phase,
  output logic [7:0]           dwell,
  output logic                 err_seq,
  output logic                 err_conflict,
  output logic                 err_dwell,
  output logic                 cycle_done,
  output logic [ERR_CNT_W-1:0] err_count
);

  lsm_state_t           r_state, w_state_nxt;
  logic [4:0]           r_phase, w_phase_nxt, w_phase_inc;
  logic [7:0]           w_sample;
  logic                 w_load, w_inc, w_adv, w_seq_err, w_cycle_done;
  logic                 w_conflict, w_short;
  logic [1:0]           w_err_inc;
  logic [ERR_CNT_W+1:0] w_cnt_sum;
  logic [ERR_CNT_W-1:0] w_cnt_nxt;
  logic                 r_err_seq, r_err_conflict, r_err_dwell, r_cycle_done;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_sample    = {hw1, hw2, fw1, fw2};
  assign w_phase_inc = (r_phase == 5'(c_num_phases - 1)) ? 5'd0 : r_phase + 5'd1;
  assign w_conflict  = ((hw1 != c_red) || (hw2 != c_red)) &&
                       ((fw1 != c_red) || (fw2 != c_red));

  // Hold is tested before advance; no two adjacent patterns are identical.
  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_load       = 1'b0;
    w_inc        = 1'b0;
    w_adv        = 1'b0;
    w_seq_err    = 1'b0;
    w_cycle_done = 1'b0;
    case (r_state)
      SYNC: begin
        if (w_sample == phase_pattern(5'd1)) begin
          w_state_nxt = TRACK;
          w_phase_nxt = 5'd1;
          w_load      = 1'b1;
        end else begin
          w_phase_nxt = 5'd0;
        end
      end
      TRACK: begin
        if (w_sample == phase_pattern(r_phase)) begin
          w_inc = 1'b1;
        end else if (w_sample == phase_pattern(w_phase_inc)) begin
          w_adv        = 1'b1;
          w_load       = 1'b1;
          w_phase_nxt  = w_phase_inc;
          w_cycle_done = (r_phase == 5'(c_num_phases - 1));
        end else begin
          w_seq_err   = 1'b1;
          w_state_nxt = SYNC;
          w_phase_nxt = 5'd0;
        end
      end
      default: begin
        w_state_nxt = SYNC;
        w_phase_nxt = 5'd0;
      end
    endcase
  end

  lsm_dwell_ctr u_dwell (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_inc   (w_inc),
`ifdef LSM_DWELL_CHECK_EN
    .i_check (w_adv),
    .i_phase (r_phase),
`endif
    .o_dwell (dwell),
    .o_short (w_short)
  );

  assign w_err_inc = {1'b0, w_seq_err} + {1'b0, w_conflict} + {1'b0, w_short};
  assign w_cnt_sum = {2'b00, r_err_count} + {{ERR_CNT_W{1'b0}}, w_err_inc};
  assign w_cnt_nxt = (|w_cnt_sum[ERR_CNT_W+1:ERR_CNT_W]) ? '1 : w_cnt_sum[ERR_CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= SYNC;
      r_phase        <= 5'd0;
      r_err_seq      <= 1'b0;
      r_err_conflict <= 1'b0;
      r_err_dwell    <= 1'b0;
      r_cycle_done   <= 1'b0;
      r_err_count    <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_phase        <= w_phase_nxt;
      r_err_seq      <= w_seq_err;
      r_err_conflict <= w_conflict;
      r_err_dwell    <= w_short;
      r_cycle_done   <= w_cycle_done;
      r_err_count    <= w_cnt_nxt;
    end
  end

  assign locked       = (r_state == TRACK);
  assign phase        = r_phase;
  assign err_seq      = r_err_seq;
  assign err_conflict = r_err_conflict;
  assign err_dwell    = r_err_dwell;
  assign cycle_done   = r_cycle_done;
  assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_light_seq_monitor.sv
`default_nettype none
// ============================================================================
// tb_light_seq_monitor : scoreboard bench for light_seq_monitor
// Rev 1.0
// ============================================================================
module tb_light_seq_monitor;

  localparam int ERR_CNT_W = 8;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
  localparam int NPH       = 18;
  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, RY = 2'b11;
`ifdef LSM_DWELL_CHECK_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           hw1 = R, hw2 = R, fw1 = R, fw2 = R;
  logic                 locked, err_seq, err_conflict, err_dwell, cycle_done;
  logic [4:0]           phase;
  logic [7:0]           dwell;
  logic [ERR_CNT_W-1:0] err_count;

  always #5 clk = ~clk;

  light_seq_monitor #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk(clk), .rst(rst), .hw1(hw1), .hw2(hw2), .fw1(fw1), .fw2(fw2),
    .locked(locked), .phase(phase), .dwell(dwell), .err_seq(err_seq),
    .err_conflict(err_conflict), .err_dwell(err_dwell), .cycle_done(cycle_done),
    .err_count(err_count)
  );

  typedef struct {
    int lk; int ph; int dw; int es; int ec; int ed; int cd; int cnt;
  } exp_t;

  exp_t       sbq[$];
  logic [1:0] pat [NPH][4];
  int         dtab [NPH] = '{1, 2, 30, 2, 10, 2, 1, 2, 15, 2, 5, 2, 10, 2, 1, 2, 15, 3};
  int         n_vec = 0;
  int         n_err = 0;

  // Reference model: which phase we believe the controller is in, and for how long.
  bit m_lk = 0;
  int m_ph = 0;
  int m_dw = 0;
  int m_cnt = 0;

  task automatic setp(input int i, input logic [1:0] a, b, c, d);
    pat[i][0] = a; pat[i][1] = b; pat[i][2] = c; pat[i][3] = d;
  endtask

  function automatic bit is_pat(input int p, input logic [1:0] a, b, c, d);
    return pat[p][0] == a && pat[p][1] == b && pat[p][2] == c && pat[p][3] == d;
  endfunction

  task automatic apply(input bit r, input logic [1:0] a, b, c, d);
    exp_t e;
    int   nxt, conf, seq, dwl, cd;
    @(negedge clk);
    rst = r; hw1 = a; hw2 = b; fw1 = c; fw2 = d;
    conf = ((a != R || b != R) && (c != R || d != R)) ? 1 : 0;
    seq = 0; dwl = 0; cd = 0;
    if (r) begin
      m_lk = 0; m_ph = 0; m_dw = 0; m_cnt = 0; conf = 0;
    end else if (!m_lk) begin
      if (is_pat(1, a, b, c, d)) begin m_lk = 1; m_ph = 1; m_dw = 1; end
      else begin m_ph = 0; m_dw = 0; end
    end else begin
      nxt = (m_ph + 1) % NPH;
      if (is_pat(m_ph, a, b, c, d)) begin
        m_dw = (m_dw < 255) ? m_dw + 1 : 255;
      end else if (is_pat(nxt, a, b, c, d)) begin
        dwl  = (DWELL_EN && m_dw < dtab[m_ph] + 1) ? 1 : 0;
        cd   = (m_ph == NPH - 1) ? 1 : 0;
        m_ph = nxt;
        m_dw = 1;
      end else begin
        seq = 1; m_lk = 0; m_ph = 0; m_dw = 0;
      end
    end
    if (!r) begin
      m_cnt = m_cnt + seq + conf + dwl;
      if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
    end
    e.lk = int'(m_lk); e.ph = m_ph; e.dw = m_dw; e.es = seq; e.ec = conf;
    e.ed = dwl; e.cd = cd; e.cnt = m_cnt;
    sbq.push_back(e);
  endtask

  task automatic apply_pat(input int p, input int n);
    for (int k = 0; k < n; k++) apply(1'b0, pat[p][0], pat[p][1], pat[p][2], pat[p][3]);
  endtask

  task automatic lap();
    for (int k = 1; k <= NPH; k++) apply_pat(k % NPH, dtab[k % NPH] + 1);
  endtask

  task automatic run_random(input int n);
    int r;
    logic [1:0] a, b, c, d;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 99));
      a = 2'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3)); d = 2'($urandom_range(0, 3));
      if (r < 1)        apply(1'b1, R, R, R, R);
      else if (r < 8)   apply(1'b0, a, b, c, d);
      else if (!m_lk)   apply_pat((r < 40) ? 1 : 0, 1);
      else if (r < 75)  apply_pat(m_ph, 1);
      else              apply_pat((m_ph + 1) % NPH, 1);
    end
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, expv);
    end
  endtask

  // Monitor: the DUT presents a registered result every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_vec++;
        chk("locked",       int'(locked),       e.lk);
        chk("phase",        int'(phase),        e.ph);
        chk("dwell",        int'(dwell),        e.dw);
        chk("err_seq",      int'(err_seq),      e.es);
        chk("err_conflict", int'(err_conflict), e.ec);
        chk("err_dwell",    int'(err_dwell),    e.ed);
        chk("cycle_done",   int'(cycle_done),   e.cd);
        chk("err_count",    int'(err_count),    e.cnt);
      end
    end
  end

  initial begin
    setp(0,  R,  R,  R,  R);  setp(1,  RY, RY, R,  R);  setp(2,  G,  G,  R,  R);
    setp(3,  G,  Y,  R,  R);  setp(4,  G,  R,  R,  R);  setp(5,  Y,  R,  R,  R);
    setp(6,  R,  R,  R,  R);  setp(7,  R,  R,  RY, RY); setp(8,  R,  R,  G,  G);
    setp(9,  R,  R,  G,  Y);  setp(10, R,  R,  G,  R);  setp(11, R,  R,  Y,  RY);
    setp(12, R,  R,  R,  G);  setp(13, R,  R,  R,  Y);  setp(14, R,  R,  R,  R);
    setp(15, R,  RY, R,  R);  setp(16, R,  G,  R,  R);  setp(17, R,  Y,  R,  R);

    repeat (3) apply(1'b1, R, R, R, R);
    apply_pat(0, 4);
    lap(); lap();
    apply_pat(1, 2);
    // Out-of-order jump from phase 2 to phase 4.
    apply_pat(2, 5); apply_pat(4, 1); apply_pat(4, 2); apply_pat(0, 3); apply_pat(1, 2);
    // Conflicts while locked and while unsynchronised.
    apply(1'b0, G, R, G, R); apply(1'b0, G, R, G, R); apply(1'b0, R, G, R, G);
    // Short and long holds of phase 2.
    apply_pat(1, 2); apply_pat(2, 20); apply_pat(3, 3); apply_pat(0, 1);
    apply_pat(1, 3); apply_pat(2, 40); apply_pat(3, 3); apply_pat(4, 11);
    // Dwell saturation, then reset mid-phase.
    apply_pat(0, 1); apply_pat(1, 3); apply_pat(2, 300);
    apply(1'b1, G, G, R, R); apply_pat(2, 2); apply_pat(1, 2);
    run_random(1500);
    apply(1'b1, R, R, R, R);
    apply(1'b0, G, G, G, G);
    apply_pat(1, 1);
    apply(1'b0, G, G, G, G);
    apply(1'b0, G, G, G, G);
    for (int k = 0; k < 300; k++) apply(1'b0, Y, R, G, R);

    repeat (4) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected results never checked, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
